stack_arbiter: RTL and testbench

- Controller that shares one LIFO stack between two requesters using round-robin arbitration.
- Owns the stack pointer and full/empty/count status.
- Sequences each push or pop through a fixed three-phase FSM against a synchronous single-port storage array.
- Sits between the pin-level command decode and the stack RAM. Requesters never touch the RAM directly.

---
 rtl/stack_pkg.sv | 17 +
 rtl/stack_ram.sv | 32 +++
 rtl/stack_arbiter.sv | 147 ++++++++++++++
 tb/tb_stack_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared definitions for the stack arbiter slice: operation encoding,
// controller state encoding and default geometry.
package stack_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 256;

  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

endpackage

// File: rtl/stack_ram.sv
// Single-port DEPTH x DATA_W storage array for the shared stack.
// Synchronous write, registered read (read-first on a same-address write).
// Ports:
//   clk    - clock
//   we     - write enable
//   addr   - word address
//   wdata  - write data
//   rdata  - read data, valid one cycle after addr is presented
module stack_ram
  import stack_pkg::*;
#(
  parameter int  DATA_W = DATA_W_DEF,
  parameter int  DEPTH  = DEPTH_DEF,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/stack_arbiter.sv
// Round-robin controller sharing one LIFO stack between two requesters.
// Owns the stack pointer and the full/empty/count status, and sequences
// every push or pop through IDLE -> ACCESS -> RESP against an external
// synchronous single-port RAM (driven through the mem_* ports).
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   clr                   - synchronous flush of the pointer (IDLE only)
//   req_valid/op/data     - per-requester request (op 0 = push, 1 = pop)
//   req_ready             - one-hot accept, high in the grant cycle
//   rsp_valid/err/data    - one-cycle completion to the granted requester
//   full, empty, count    - occupancy status decoded from the pointer
//   mem_we/addr/wdata     - RAM command
//   mem_rdata             - RAM registered read data
module stack_arbiter
  import stack_pkg::*;
#(
  parameter int  DATA_W = DATA_W_DEF,
  parameter int  DEPTH  = DEPTH_DEF,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic [1:0]          req_valid,
  input  logic [1:0]          req_op,
  input  logic [2*DATA_W-1:0] req_data,
  output logic [1:0]          req_ready,
  output logic [1:0]          rsp_valid,
  output logic                rsp_err,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                full,
  output logic                empty,
  output logic [AW:0]         count,
  output logic                mem_we,
  output logic [AW-1:0]       mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam logic [AW:0] SP_ONE  = (AW+1)'(1);
  localparam logic [AW:0] SP_FULL = (AW+1)'(DEPTH);

  state_t            state_q, state_d;
  logic [AW:0]       sp_q, sp_d;
  logic [AW:0]       sp_dec;
  logic              last_grant_q, last_grant_d;
  logic              win;
  logic              grant;
  logic              op_err;

  logic              win_p0;
  logic              op_p0;
  logic [DATA_W-1:0] data_p0;
  logic              err_p1;

  assign full   = (sp_q == SP_FULL);
  assign empty  = (sp_q == '0);
  assign count  = sp_q;
  assign sp_dec = sp_q - SP_ONE;

  // With both requesters valid the one that did not win last time goes.
  assign win    = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];
  assign grant  = (state_q == S_IDLE) && !clr && (|req_valid);
  assign op_err = (op_p0 == OP_PUSH) ? full : empty;

  always_comb begin
    state_d      = state_q;
    sp_d         = sp_q;
    last_grant_d = last_grant_q;
    req_ready    = '0;
    rsp_valid    = '0;
    rsp_err      = 1'b0;
    rsp_data     = '0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    case (state_q)
      S_IDLE: begin
        if (clr) begin
          sp_d = '0;
        end else if (|req_valid) begin
          req_ready[win] = 1'b1;
          last_grant_d   = win;
          state_d        = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (!op_err) begin
          if (op_p0 == OP_PUSH) begin
            mem_we    = 1'b1;
            mem_addr  = sp_q[AW-1:0];
            mem_wdata = data_p0;
          end else begin
            mem_addr  = sp_dec[AW-1:0];
          end
        end
        state_d = S_RESP;
      end
      S_RESP: begin
        rsp_valid[win_p0] = 1'b1;
        rsp_err           = err_p1;
        if (!err_p1) begin
          if (op_p0 == OP_POP) begin
            rsp_data = mem_rdata;
            sp_d     = sp_dec;
          end else begin
            sp_d     = sp_q + SP_ONE;
          end
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Accept stage: control state and latched request attributes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      sp_q         <= '0;
      last_grant_q <= 1'b1;
      win_p0       <= 1'b0;
      op_p0        <= OP_PUSH;
      err_p1       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sp_q         <= sp_d;
      last_grant_q <= last_grant_d;
      if (grant) begin
        win_p0 <= win;
        op_p0  <= req_op[win];
      end
      // Access stage: error decision frozen for the response cycle.
      if (state_q == S_ACCESS) begin
        err_p1 <= op_err;
      end
    end
  end

  // Push data is never observed before it is captured, so it needs no reset.
  always_ff @(posedge clk) begin
    if (grant) begin
      data_p0 <= win ? req_data[2*DATA_W-1:DATA_W] : req_data[DATA_W-1:0];
    end
  end

endmodule

// File: tb/tb_stack_arbiter.sv
`timescale 1ns/1ps
module tb_stack_arbiter;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 256;
  localparam int AW     = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              clr;
  logic [1:0]        req_valid;
  logic [1:0]        req_op;
  logic [15:0]       req_data;
  logic [1:0]        req_ready;
  logic [1:0]        rsp_valid;
  logic              rsp_err;
  logic [7:0]        rsp_data;
  logic              full;
  logic              empty;
  logic [AW:0]       count;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  stack_arbiter #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .req_valid(req_valid), .req_op(req_op), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
    .rsp_data(rsp_data), .full(full), .empty(empty), .count(count),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  stack_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
    .clk(clk), .we(mem_we), .addr(mem_addr), .wdata(mem_wdata), .rdata(mem_rdata)
  );

  // One complete operation; starts and ends 1ns after a rising edge in IDLE.
  task automatic run_op(input int r, input logic op, input logic [7:0] d,
                        output logic [1:0] rdy, output logic we,
                        output logic [7:0] addr, output logic [7:0] wd,
                        output logic [1:0] rv, output logic re,
                        output logic [7:0] rd);
    req_valid = 2'b00;
    req_valid[r] = 1'b1;
    req_op[r] = op;
    req_data[r*8 +: 8] = d;
    @(negedge clk); rdy = req_ready;
    @(posedge clk); #1;
    req_valid = 2'b00;
    req_op[r] = ~op;
    req_data[r*8 +: 8] = ~d;
    @(negedge clk); we = mem_we; addr = mem_addr; wd = mem_wdata;
    @(posedge clk); #1;
    @(negedge clk); rv = rsp_valid; re = rsp_err; rd = rsp_data;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; clr = 1'b0; req_valid = 2'b00; req_op = 2'b00; req_data = '0;
    #3;
    vectors++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready got %b want 00", req_ready); end
    vectors++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got %b want 00", rsp_valid); end
    vectors++; if (rsp_err !== 1'b0 || rsp_data !== 8'h00) begin errors++; $display("FAIL reset_rsp got err=%b data=%h want 0/00", rsp_err, rsp_data); end
    vectors++; if (empty !== 1'b1 || full !== 1'b0 || count !== 9'd0) begin errors++; $display("FAIL reset_status got e=%b f=%b c=%0d want 1/0/0", empty, full, count); end
    vectors++; if (mem_we !== 1'b0 || mem_addr !== 8'h00 || mem_wdata !== 8'h00) begin errors++; $display("FAIL reset_mem got we=%b a=%h d=%h want 0/00/00", mem_we, mem_addr, mem_wdata); end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_first_push;
    logic [1:0] rdy, rv; logic we, re; logic [7:0] a, wd, rd;
    run_op(0, 1'b0, 8'hA5, rdy, we, a, wd, rv, re, rd);
    vectors++; if (rdy !== 2'b01) begin errors++; $display("FAIL push_ready got %b want 01", rdy); end
    vectors++; if (we !== 1'b1 || a !== 8'h00 || wd !== 8'hA5) begin errors++; $display("FAIL push_mem got we=%b a=%h d=%h want 1/00/a5", we, a, wd); end
    vectors++; if (rv !== 2'b01 || re !== 1'b0 || rd !== 8'h00) begin errors++; $display("FAIL push_rsp got v=%b e=%b d=%h want 01/0/00", rv, re, rd); end
    vectors++; if (count !== 9'd1 || empty !== 1'b0) begin errors++; $display("FAIL push_count got c=%0d e=%b want 1/0", count, empty); end
  endtask

  task automatic test_lifo;
    logic [1:0] rdy, rv; logic we, re; logic [7:0] a, wd, rd;
    logic [7:0] pushes [3];
    logic [7:0] pops [4];
    pushes = '{8'h11, 8'h22, 8'h33};
    pops   = '{8'h33, 8'h22, 8'h11, 8'hA5};
    for (int i = 0; i < 3; i++) begin
      run_op(0, 1'b0, pushes[i], rdy, we, a, wd, rv, re, rd);
      vectors++; if (a !== 8'(i + 1) || re !== 1'b0) begin errors++; $display("FAIL lifo_push%0d got a=%h e=%b want %h/0", i, a, re, 8'(i + 1)); end
    end
    for (int i = 0; i < 4; i++) begin
      run_op(1, 1'b1, 8'h00, rdy, we, a, wd, rv, re, rd);
      vectors++; if (rdy !== 2'b10 || we !== 1'b0 || a !== 8'(3 - i)) begin errors++; $display("FAIL lifo_pop%0d_cmd got r=%b we=%b a=%h want 10/0/%h", i, rdy, we, a, 8'(3 - i)); end
      vectors++; if (rv !== 2'b10 || re !== 1'b0 || rd !== pops[i]) begin errors++; $display("FAIL lifo_pop%0d_rsp got v=%b e=%b d=%h want 10/0/%h", i, rv, re, rd, pops[i]); end
    end
    vectors++; if (count !== 9'd0 || empty !== 1'b1) begin errors++; $display("FAIL lifo_end got c=%0d e=%b want 0/1", count, empty); end
  endtask

  task automatic test_pop_empty;
    logic [1:0] rdy, rv; logic we, re; logic [7:0] a, wd, rd;
    run_op(0, 1'b1, 8'h00, rdy, we, a, wd, rv, re, rd);
    vectors++; if (rv !== 2'b01 || re !== 1'b1 || rd !== 8'h00 || we !== 1'b0) begin errors++; $display("FAIL pop_empty got v=%b e=%b d=%h we=%b want 01/1/00/0", rv, re, rd, we); end
    vectors++; if (count !== 9'd0 || empty !== 1'b1) begin errors++; $display("FAIL pop_empty_count got c=%0d e=%b want 0/1", count, empty); end
  endtask

  task automatic test_full;
    logic [1:0] rdy, rv; logic we, re; logic [7:0] a, wd, rd;
    int bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      run_op(0, 1'b0, 8'(i) ^ 8'h5A, rdy, we, a, wd, rv, re, rd);
      if (re !== 1'b0 || we !== 1'b1 || a !== 8'(i)) bad++;
    end
    vectors++; if (bad != 0) begin errors++; $display("FAIL fill got %0d bad pushes want 0", bad); end
    vectors++; if (count !== 9'd256 || full !== 1'b1 || empty !== 1'b0) begin errors++; $display("FAIL fill_status got c=%0d f=%b e=%b want 256/1/0", count, full, empty); end
    run_op(0, 1'b0, 8'hFF, rdy, we, a, wd, rv, re, rd);
    vectors++; if (rv !== 2'b01 || re !== 1'b1 || we !== 1'b0) begin errors++; $display("FAIL push_full got v=%b e=%b we=%b want 01/1/0", rv, re, we); end
    vectors++; if (count !== 9'd256 || full !== 1'b1) begin errors++; $display("FAIL push_full_count got c=%0d f=%b want 256/1", count, full); end
    run_op(1, 1'b1, 8'h00, rdy, we, a, wd, rv, re, rd);
    vectors++; if (a !== 8'hFF || rv !== 2'b10 || re !== 1'b0 || rd !== 8'hA5) begin errors++; $display("FAIL pop_full got a=%h v=%b e=%b d=%h want ff/10/0/a5", a, rv, re, rd); end
    vectors++; if (count !== 9'd255 || full !== 1'b0) begin errors++; $display("FAIL pop_full_count got c=%0d f=%b want 255/0", count, full); end
  endtask

  // Requester 0 pushes, requester 1 pops; both hold valid for six operations.
  task automatic test_back_to_back;
    logic [1:0] exp;
    req_op = 2'b10;
    for (int k = 0; k < 6; k++) begin
      req_valid = 2'b11;
      req_data[7:0] = 8'h10 + 8'(k);
      exp = (k % 2 == 0) ? 2'b01 : 2'b10;
      @(negedge clk);
      vectors++; if (req_ready !== exp) begin errors++; $display("FAIL rr_grant%0d got %b want %b", k, req_ready, exp); end
      @(posedge clk); #1;
      @(negedge clk);
      vectors++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rr_busy%0d got %b want 00", k, req_ready); end
      @(posedge clk); #1;
      @(negedge clk);
      vectors++; if (rsp_valid !== exp || rsp_err !== 1'b0) begin errors++; $display("FAIL rr_rsp%0d got v=%b e=%b want %b/0", k, rsp_valid, rsp_err, exp); end
      if (k % 2 == 1) begin
        vectors++; if (rsp_data !== 8'h10 + 8'(k - 1)) begin errors++; $display("FAIL rr_data%0d got %h want %h", k, rsp_data, 8'h10 + 8'(k - 1)); end
      end
      @(posedge clk); #1;
    end
    req_valid = 2'b00;
    vectors++; if (count !== 9'd255) begin errors++; $display("FAIL rr_count got %0d want 255", count); end
  endtask

  task automatic test_clr_and_abort;
    logic [1:0] rdy, rv; logic we, re; logic [7:0] a, wd, rd;
    clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    vectors++; if (count !== 9'd0) begin errors++; $display("FAIL clr_flush got %0d want 0", count); end
    for (int i = 1; i <= 5; i++) run_op(0, 1'b0, 8'(i), rdy, we, a, wd, rv, re, rd);
    vectors++; if (count !== 9'd5) begin errors++; $display("FAIL clr_prefill got %0d want 5", count); end
    clr = 1'b1; req_valid = 2'b01; req_op = 2'b00; req_data[7:0] = 8'h77;
    @(negedge clk);
    vectors++; if (req_ready !== 2'b00) begin errors++; $display("FAIL clr_ready got %b want 00", req_ready); end
    @(posedge clk); #1 clr = 1'b0;
    vectors++; if (count !== 9'd0 || empty !== 1'b1) begin errors++; $display("FAIL clr_count got c=%0d e=%b want 0/1", count, empty); end
    @(negedge clk);
    vectors++; if (req_ready !== 2'b01) begin errors++; $display("FAIL clr_then_grant got %b want 01", req_ready); end
    @(posedge clk); #1 req_valid = 2'b00;
    @(negedge clk);
    vectors++; if (mem_we !== 1'b1 || mem_addr !== 8'h00 || mem_wdata !== 8'h77) begin errors++; $display("FAIL abort_access got we=%b a=%h d=%h want 1/00/77", mem_we, mem_addr, mem_wdata); end
    rst_n = 1'b0;
    #1;
    vectors++; if (mem_we !== 1'b0 || rsp_valid !== 2'b00 || count !== 9'd0 || empty !== 1'b1) begin errors++; $display("FAIL abort_reset got we=%b v=%b c=%0d e=%b want 0/00/0/1", mem_we, rsp_valid, count, empty); end
    @(posedge clk); #1;
    vectors++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL abort_no_rsp got %b want 00", rsp_valid); end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++; if (rsp_valid !== 2'b00 || count !== 9'd0) begin errors++; $display("FAIL abort_after got v=%b c=%0d want 00/0", rsp_valid, count); end
    @(posedge clk); #1;
    // After reset requester 0 must win a simultaneous request.
    req_valid = 2'b11; req_op = 2'b11;
    @(negedge clk);
    vectors++; if (req_ready !== 2'b01) begin errors++; $display("FAIL reset_rr_first got %b want 01", req_ready); end
    @(posedge clk); #1 req_valid = 2'b00;
    @(posedge clk); #1;
    @(negedge clk);
    vectors++; if (rsp_valid !== 2'b01 || rsp_err !== 1'b1 || rsp_data !== 8'h00) begin errors++; $display("FAIL reset_pop_empty got v=%b e=%b d=%h want 01/1/00", rsp_valid, rsp_err, rsp_data); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_first_push();
    test_lifo();
    test_pop_empty();
    test_full();
    test_back_to_back();
    test_clr_and_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
